// File: rtl/wb_sel_pipe_if.sv
// Upstream M/W beat presented to the writeback selector.
interface wb_sel_pipe_if #(
  parameter int unsigned DW   = 32,
  parameter int unsigned NSRC = 8,
  parameter int unsigned SELW = 3,
  parameter int unsigned REGW = 5
);
  logic               in_valid;
  logic               in_ready;
  logic [SELW-1:0]    in_sel;
  logic [NSRC*DW-1:0] src_data;
  logic [REGW-1:0]    in_rt;
  logic [REGW-1:0]    in_rd;
  logic [1:0]         in_dst;
  logic [DW-1:0]      in_pc;
  logic [2:0]         in_ld_mode;
  logic [1:0]         in_addr_lo;

  modport master (
    output in_valid, in_sel, src_data, in_rt, in_rd, in_dst, in_pc, in_ld_mode, in_addr_lo,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_sel, src_data, in_rt, in_rd, in_dst, in_pc, in_ld_mode, in_addr_lo,
    output in_ready
  );
endinterface

// File: rtl/wb_sel_pipe.sv
// W-stage writeback selector: source mux, load extraction, link address,
// destination resolution, HI/LO hold while mult/div busy, stall counter.
module wb_sel_pipe #(
  parameter int unsigned DW       = 32,
  parameter int unsigned NSRC     = 8,
  parameter int unsigned SELW     = 3,
  parameter int unsigned REGW     = 5,
  parameter int unsigned DM_IDX   = 1,
  parameter int unsigned LINK_IDX = 3,
  parameter int unsigned HI_IDX   = 4,
  parameter int unsigned LO_IDX   = 5,
  parameter int unsigned LINK_OFS = 8,
  parameter int unsigned CW       = 16
) (
  input  logic            clk,
  input  logic            reset,
  wb_sel_pipe_if.slave    bus,
  input  logic            md_busy,
  input  logic            flush,
  input  logic            stall_clr,
  output logic            out_valid,
  output logic            out_we,
  output logic [REGW-1:0] out_wreg,
  output logic [DW-1:0]   out_wdata,
  output logic [CW-1:0]   stall_cnt
);

  logic            md_hold_c;
  logic            accept_c;
  logic [DW-1:0]   src_sel_c;
  logic [DW-1:0]   dm_word_c;
  logic [7:0]      ld_byte_c;
  logic [15:0]     ld_half_c;
  logic [DW-1:0]   ld_data_c;
  logic [DW-1:0]   wdata_c;
  logic [REGW-1:0] wreg_c;
  logic            we_c;

  // Handshake: HI/LO readers wait for the mult/div unit; flush blocks acceptance.
  always_comb begin
    md_hold_c    = bus.in_valid & md_busy &
                   ((bus.in_sel == SELW'(HI_IDX)) | (bus.in_sel == SELW'(LO_IDX)));
    bus.in_ready = ~md_hold_c & ~flush;
    accept_c     = bus.in_valid & bus.in_ready;
  end

  // Plain source mux; selects beyond NSRC fall through to zero.
  always_comb begin
    src_sel_c = '0;
    for (int unsigned k = 0; k < NSRC; k++) begin
      if (bus.in_sel == SELW'(k)) src_sel_c = bus.src_data[k*DW +: DW];
    end
  end

  // Load extraction from the raw DM word; halves ignore addr bit 0.
  always_comb begin
    dm_word_c = bus.src_data[DM_IDX*DW +: DW];
    ld_byte_c = dm_word_c[{bus.in_addr_lo, 3'b000} +: 8];
    ld_half_c = dm_word_c[{bus.in_addr_lo[1], 4'b0000} +: 16];
    case (bus.in_ld_mode)
      3'd1:    ld_data_c = {{(DW-8){ld_byte_c[7]}}, ld_byte_c};
      3'd2:    ld_data_c = {{(DW-8){1'b0}}, ld_byte_c};
      3'd3:    ld_data_c = {{(DW-16){ld_half_c[15]}}, ld_half_c};
      3'd4:    ld_data_c = {{(DW-16){1'b0}}, ld_half_c};
      default: ld_data_c = dm_word_c;
    endcase
  end

  always_comb begin
    if (bus.in_sel == SELW'(LINK_IDX))    wdata_c = bus.in_pc + DW'(LINK_OFS);
    else if (bus.in_sel == SELW'(DM_IDX)) wdata_c = ld_data_c;
    else                                  wdata_c = src_sel_c;
  end

  // Destination resolution; "no write" still reports the rt field.
  always_comb begin
    case (bus.in_dst)
      2'd1:    wreg_c = bus.in_rd;
      2'd2:    wreg_c = REGW'(31);
      default: wreg_c = bus.in_rt;
    endcase
    we_c = (bus.in_dst != 2'd3) && (wreg_c != '0);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_we    <= 1'b0;
      out_wreg  <= '0;
      out_wdata <= '0;
      stall_cnt <= '0;
    end else begin
      out_valid <= accept_c;
      out_we    <= accept_c & we_c;
      if (accept_c) begin
        out_wreg  <= wreg_c;
        out_wdata <= wdata_c;
      end
      // Clear wins over a same-cycle increment; count saturates.
      if (stall_clr) begin
        stall_cnt <= '0;
      end else if (md_hold_c && !flush && (stall_cnt != {CW{1'b1}})) begin
        stall_cnt <= stall_cnt + CW'(1);
      end
    end
  end

endmodule
